cp0_irq_unit: RTL and testbench
===============================

// Module: cp0_irq_unit
// PURPOSE
//  Coprocessor-0 exception/interrupt unit: the CPU-side receiver of peripheral IRQ lines
//  (timer0, timer1, external) and of pipeline exception codes. Holds SR/Cause/EPC/PRId,
//  raises a single Req to flush the pipeline and redirect to the handler, and supports
//  mtc0/mfc0/eret. Sits beside the M stage of the 5-stage pipeline.
// PARAMETERS
//  PRID     32'h0000_7777  read-only value of PRId (reg 15)
//  HWINT_W  6              number of hardware interrupt lines (maps to IM/IP bits 15:10)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears all state immediately
//  A1         in   5   mfc0 read register number
//  A2         in   5   mtc0 write register number
//  Din        in   32  mtc0 write data
//  WE         in   1   mtc0 write enable
//  PC         in   32  PC of the instruction currently in M stage
//  BD         in   1   M-stage instruction sits in a branch delay slot
//  ExcCodeIn  in   5   pending exception code from M stage, 0 = none
//  HWInt      in   6   [0]=timer0 IRQ, [1]=timer1 IRQ, [2]=external, [5:3]=tie 0
//  EXLClr     in   1   eret in M stage
//  Req        out  1   take exception/interrupt this cycle (combinational)
//  EPC        out  32  current EPC register value
//  Dout       out  32  mfc0 read data (combinational on A1)
// BEHAVIOUR
//  Registers: SR(12)={16'b0,IM[15:10],8'b0,EXL[1],IE[0]}; Cause(13)={BD[31],15'b0,
//   IP[15:10],3'b0,ExcCode[6:2],2'b0}; EPC(14) 32b, bits[1:0] always 0; PRId(15)=PRID.
//   Unlisted bits read 0, ignore writes. Dout=0 for any other A1.
//  Reset: SR=0, Cause=0, EPC=0 -> Req=0, EPC=0, Dout=0 (or PRID when A1=15).
//  IntReq = |(HWInt & IM) & IE & ~EXL, from live HWInt (same-cycle, no latency).
//  ExcReq = (ExcCodeIn != 0) & ~EXL.  Req = IntReq | ExcReq.
//  IP[15:10] <= HWInt every cycle (readable via mfc0 one cycle after HWInt changes).
//  On posedge with Req=1: EXL<=1; Cause.BD<=BD; ExcCode<=IntReq ? 5'd0 : ExcCodeIn
//   (interrupt has priority over synchronous exception);
//   EPC <= BD ? {PC[31:2],2'b0}-4 : {PC[31:2],2'b0}.
//  Priority on same edge: Req > EXLClr > WE. With Req, mtc0 write is dropped entirely.
//   EXLClr without Req: EXL<=0; a concurrent WE to SR updates IM/IE but EXL ends 0.
//  mtc0 to Cause: writes nothing (IP/ExcCode/BD are hardware-owned). mtc0 to EPC:
//   EPC<={Din[31:2],2'b0}. mtc0 to PRId ignored.
//  While EXL=1 no new Req, regardless of HWInt or ExcCodeIn.
//  Level-sensitive: timer IRQ held high re-requests after eret until software
//   clears it at the timer; no edge detection here.
//  PC-4 wraps modulo 2^32 (PC=0 with BD -> EPC=32'hFFFF_FFFC).
//  Reset asserted mid-handler: EXL, IM, IE clear at once; Req drops combinationally.
// STRUCTURE
//  Shared header cp0_defs.vh: `define CP0_SR 12, CP0_CAUSE 13, CP0_EPC 14, CP0_PRID 15;
//   bit-field positions (IM_HI 15, IM_LO 10, EXL 1, IE 0, BD 31, EXC_HI 6, EXC_LO 2);
//   ExcCodes INT 0, ADEL 4, ADES 5, RI 10, OV 12.
//  No sub-module: single file, one always block per register plus combinational read mux.
// TESTING
//  1 Reset: hold reset, then read A1=12/13/14 -> 0; A1=15 -> PRID; Req=0.
//  2 Timer IRQ: mtc0 SR=32'h0000_0401, HWInt=6'b000001, PC=32'h0000_3010, BD=0 -> Req=1
//    same cycle; next edge SR=32'h0000_0403, Cause=32'h0000_0400, EPC=32'h0000_3010.
//  3 Masked/blocked: IM=0 or IE=0 or EXL=1 with HWInt=6'b111 -> Req=0; IP still tracks.
//  4 Delay slot exception: ExcCodeIn=12, BD=1, PC=32'h0000_3020 -> EPC=32'h0000_301C,
//    Cause=32'h8000_0030; simultaneous HWInt[0] enabled -> ExcCode=0 instead.
//  5 eret + level IRQ: EXLClr=1 with HWInt[0] still high -> next cycle EXL=0, Req=1 again.
//  6 Collision: Req and WE(A2=14,Din=32'h1234_5678) same edge -> EPC from PC, write lost;
//    async reset pulse mid-cycle -> EXL/Req to 0 before next clock edge.

Source files
------------

// File: rtl/cp0_irq_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes.
package cp0_irq_unit_pkg;

  localparam int unsigned HWINT_W = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned XLEN    = 32;

  localparam logic [REG_W-1:0] CP0_SR    = 5'd12;
  localparam logic [REG_W-1:0] CP0_CAUSE = 5'd13;
  localparam logic [REG_W-1:0] CP0_EPC   = 5'd14;
  localparam logic [REG_W-1:0] CP0_PRID  = 5'd15;

  localparam int unsigned IM_HI  = 15;
  localparam int unsigned IM_LO  = 10;
  localparam int unsigned EXL    = 1;
  localparam int unsigned IE     = 0;
  localparam int unsigned BD_POS = 31;
  localparam int unsigned EXC_HI = 6;
  localparam int unsigned EXC_LO = 2;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [4:0]         exc_code;
  } cause_t;

  function automatic logic [XLEN-1:0] pack_sr(input sr_t s);
    return {16'b0, s.im, 8'b0, s.exl, s.ie};
  endfunction

  function automatic logic [XLEN-1:0] pack_cause(input cause_t c);
    return {c.bd, 15'b0, c.ip, 3'b0, c.exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_irq_unit.sv
// CP0 exception/interrupt unit: SR/Cause/EPC/PRId, exception request, mtc0/mfc0/eret.
module cp0_irq_unit
  import cp0_irq_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_7777
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   A1,
  input  logic [REG_W-1:0]   A2,
  input  logic [XLEN-1:0]    Din,
  input  logic               WE,
  input  logic [XLEN-1:0]    PC,
  input  logic               BD,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic               Req,
  output logic [XLEN-1:0]    EPC,
  output logic [XLEN-1:0]    Dout
);

  sr_t          sr_q;
  cause_t       cause_q;
  logic [29:0]  epc_q;

  logic         int_req;
  logic         exc_req;
  logic         sr_we;
  logic         epc_we;
  logic [29:0]  epc_next;

  // Requests are evaluated from live inputs; EXL masks both kinds.
  assign int_req = (|(HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign exc_req = (ExcCodeIn != EXC_INT) & ~sr_q.exl;
  assign Req     = int_req | exc_req;

  assign sr_we   = WE & (A2 == CP0_SR);
  assign epc_we  = WE & (A2 == CP0_EPC);

  // Delay-slot instructions restart at the preceding branch (word-aligned, wraps).
  assign epc_next = BD ? (PC[31:2] - 30'd1) : PC[31:2];

  // SR: exception entry beats eret, which beats an mtc0 write to EXL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (Req) begin
      sr_q.exl <= 1'b1;
    end else begin
      if (sr_we) begin
        sr_q.im  <= Din[IM_HI:IM_LO];
        sr_q.exl <= Din[EXL];
        sr_q.ie  <= Din[IE];
      end
      if (EXLClr) begin
        sr_q.exl <= 1'b0;
      end
    end
  end

  // Cause is hardware-owned; IP mirrors HWInt with one cycle of delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cause_q <= '0;
    end else begin
      cause_q.ip <= HWInt;
      if (Req) begin
        cause_q.bd       <= BD;
        cause_q.exc_code <= int_req ? EXC_INT : ExcCodeIn;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_q <= '0;
    end else if (Req) begin
      epc_q <= epc_next;
    end else if (epc_we) begin
      epc_q <= Din[31:2];
    end
  end

  assign EPC = {epc_q, 2'b00};

  // mfc0 read mux.
  always_comb begin
    Dout = '0;
    case (A1)
      CP0_SR:    Dout = pack_sr(sr_q);
      CP0_CAUSE: Dout = pack_cause(cause_q);
      CP0_EPC:   Dout = {epc_q, 2'b00};
      CP0_PRID:  Dout = PRID;
      default:   Dout = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{Din[XLEN-1:IM_HI+1], Din[IM_LO-1:EXL+1], PC[1:0]};

endmodule

// File: tb/tb_cp0_irq_unit.sv
// Directed self-checking bench for cp0_irq_unit.
module tb_cp0_irq_unit;
  import cp0_irq_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] Din, PC;
  logic        WE, BD, EXLClr;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPC, Dout;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_irq_unit #(.PRID(32'h0000_7777)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .PC(PC), .BD(BD), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .Req(Req), .EPC(EPC), .Dout(Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
    A1 = r;
    #1;
    check_eq(tag, Dout, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    WE = 1'b1; A2 = r; Din = d;
    tick();
    WE = 1'b0; A2 = '0; Din = '0;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; Din = '0; WE = 1'b0; PC = '0; BD = 1'b0;
    ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc_rd", 32'h0);
    rd(5'd15, "rst_prid", 32'h0000_7777);
    check_eq("rst_req", 32'(Req), 32'h0);
    check_eq("rst_epc", EPC, 32'h0);
    reset = 1'b0;
    tick();

    // Cause and PRId are not software-writable; unknown A1 reads 0
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_wr_ignored", 32'h0);
    mtc0(5'd15, 32'h0);
    rd(5'd15, "prid_wr_ignored", 32'h0000_7777);
    rd(5'd3, "unlisted_a1", 32'h0);

    // Timer interrupt
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "sr_after_mtc0", 32'h0000_0401);
    HWInt = 6'b000001; PC = 32'h0000_3010; BD = 1'b0;
    #1;
    check_eq("irq_req_same_cycle", 32'(Req), 32'h1);
    tick();
    check_eq("irq_req_blocked_exl", 32'(Req), 32'h0);
    rd(5'd12, "irq_sr", 32'h0000_0403);
    rd(5'd13, "irq_cause", 32'h0000_0400);
    check_eq("irq_epc", EPC, 32'h0000_3010);

    // eret with level IRQ still high re-requests
    EXLClr = 1'b1;
    #1;
    check_eq("eret_req_before_edge", 32'(Req), 32'h0);
    tick();
    EXLClr = 1'b0;
    #1;
    check_eq("eret_level_rereq", 32'(Req), 32'h1);
    rd(5'd12, "eret_sr", 32'h0000_0401);
    tick();

    // EXL blocks everything; IP tracks
    HWInt = 6'b000111; ExcCodeIn = EXC_OV;
    #1;
    check_eq("exl_blocks", 32'(Req), 32'h0);
    tick();
    rd(5'd13, "ip_tracks_under_exl", 32'h0000_1C00);
    ExcCodeIn = '0; HWInt = '0;
    eret();

    // IE=0 and IM=0 masking
    mtc0(5'd12, 32'h0000_FC00);
    HWInt = 6'b000111;
    #1;
    check_eq("ie0_masks", 32'(Req), 32'h0);
    HWInt = '0;
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'b000111;
    #1;
    check_eq("im0_masks", 32'(Req), 32'h0);
    tick();
    rd(5'd13, "ip_tracks_masked", 32'h0000_1C00);
    HWInt = '0;

    // Delay-slot overflow exception
    ExcCodeIn = EXC_OV; BD = 1'b1; PC = 32'h0000_3020;
    #1;
    check_eq("exc_req", 32'(Req), 32'h1);
    tick();
    ExcCodeIn = '0; BD = 1'b0;
    check_eq("bd_epc", EPC, 32'h0000_301C);
    rd(5'd13, "bd_cause", 32'h8000_0030);
    rd(5'd12, "bd_sr", 32'h0000_0003);

    // eret with concurrent SR write: IM/IE taken, EXL ends 0
    WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
    tick();
    WE = 1'b0; EXLClr = 1'b0; Din = '0;
    rd(5'd12, "eret_wr_sr", 32'h0000_0401);

    // Interrupt beats simultaneous exception
    HWInt = 6'b000001; ExcCodeIn = EXC_OV; BD = 1'b1; PC = 32'h0000_3020;
    tick();
    ExcCodeIn = '0; BD = 1'b0; HWInt = '0;
    rd(5'd13, "int_prio_cause", 32'h8000_0400);
    check_eq("int_prio_epc", EPC, 32'h0000_301C);
    eret();

    // mtc0 EPC clears low bits
    mtc0(5'd14, 32'h1234_5677);
    check_eq("mtc0_epc", EPC, 32'h1234_5674);

    // PC-4 wraps
    ExcCodeIn = EXC_RI; BD = 1'b1; PC = 32'h0000_0000;
    tick();
    ExcCodeIn = '0; BD = 1'b0;
    check_eq("epc_wrap", EPC, 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0028);
    eret();

    // Collision: Req drops concurrent EPC write
    HWInt = 6'b000001; PC = 32'h0000_4000; BD = 1'b0;
    WE = 1'b1; A2 = 5'd14; Din = 32'h1234_5678;
    tick();
    WE = 1'b0; Din = '0;
    check_eq("collision_epc", EPC, 32'h0000_4000);
    rd(5'd12, "collision_sr", 32'h0000_0403);

    // Async reset mid-cycle with Req active
    eret();
    A1 = 5'd12;
    #1;
    check_eq("pre_reset_req", 32'(Req), 32'h1);
    reset = 1'b1;
    #1;
    check_eq("async_reset_req", 32'(Req), 32'h0);
    check_eq("async_reset_sr", Dout, 32'h0);
    check_eq("async_reset_epc", EPC, 32'h0);
    reset = 1'b0;
    HWInt = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
